// File: rtl/sw_key_debounce.sv
// Switch/key front end: 2-flop synchronisers, per-bit stability debounce and a key-0 press counter.
// Registered outputs are the words read at I/O input ports 0 and 1.
module sw_key_debounce #(
    parameter int SW_W         = 10,
    parameter int KEY_W        = 4,
    parameter int DEBOUNCE_CNT = 500000,
    parameter int CNT_W        = 20
) (
    input  logic              io_clk,
    input  logic              resetn,
    input  logic [SW_W-1:0]   sw,
    input  logic [KEY_W-1:0]  key_n,
    output logic [31:0]       in_port0,
    output logic [31:0]       in_port1
);
    localparam int N = SW_W + KEY_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic [SW_W-1:0]  sw_s1;
    logic [SW_W-1:0]  sw_s2;
    logic [KEY_W-1:0] key_s1;
    logic [KEY_W-1:0] key_s2;
    logic [N-1:0]     sync_bits;
    logic [N-1:0]     stable;
    logic [CNT_W-1:0] cnt [N];
    logic [15:0]      press_cnt;
    logic             key0_accept;

    // Key sync stages reset to 1 so a released key is the idle level.
    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            key_s1 <= '1;
            key_s2 <= '1;
        end else begin
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
            key_s1 <= key_n;
            key_s2 <= key_s1;
        end
    end

    // Keys are inverted here so every downstream bit is active-high.
    assign sync_bits = {~key_s2, sw_s2};

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            stable <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sync_bits[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync_bits[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Counts on the same edge that key 0 is accepted as pressed.
    assign key0_accept = sync_bits[SW_W] & ~stable[SW_W] & (cnt[SW_W] == CNT_LAST);

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            press_cnt <= '0;
        end else if (key0_accept) begin
            press_cnt <= press_cnt + 16'd1;
        end
    end

    assign in_port0 = 32'(stable[SW_W-1:0]);
    assign in_port1 = {press_cnt, 16'(stable[N-1:SW_W])};

endmodule
